// File: rtl/ntt_mem_arbiter.sv
// ntt_mem_arbiter: round-robin arbiter sharing one memory port among NUM_CORES NTT cores,
// with read-data routing and a read-response watchdog.
module ntt_mem_arbiter #(
   parameter int NUM_CORES = 4,
   parameter int ADDR_W    = 48,
   parameter int DATA_W    = 64,
   parameter int TIMEOUT   = 1024
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_CORES-1:0]        core_req,
   input  logic [NUM_CORES-1:0]        core_we,
   input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
   input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
   output logic [NUM_CORES-1:0]        core_gnt,
   output logic [NUM_CORES-1:0]        core_valid,
   output logic [DATA_W-1:0]           core_rdata,
   output logic                        mem_req,
   output logic                        mem_we,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   input  logic                        mem_ready,
   input  logic                        mem_rvalid,
   input  logic [DATA_W-1:0]           mem_rdata,
   output logic                        err_timeout,
   output logic [2:0]                  err_core,
   output logic [31:0]                 grant_count
);
   localparam int WD_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;

   state_t                   state_q, state_d;
   logic [2:0]               rr_ptr_q, rr_ptr_d, owner_q, owner_d, err_core_q, err_core_d;
   logic [WD_W-1:0]          wd_q, wd_d;
   logic [NUM_CORES-1:0]     gnt_q, gnt_d, valid_q, valid_d;
   logic [DATA_W-1:0]        rdata_q, rdata_d, mem_wdata_q, mem_wdata_d;
   logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
   logic                     mem_req_q, mem_req_d, mem_we_q, mem_we_d, err_q, err_d;
   logic [31:0]              grant_count_q, grant_count_d;

   logic [2*NUM_CORES-1:0]   req2;
   logic [NUM_CORES-1:0]     rot;
   logic [2:0]               off, win;
   logic [3:0]               sum;
   logic                     sel_we;
   logic [ADDR_W-1:0]        sel_addr;
   logic [DATA_W-1:0]        sel_wdata;

   // Rotate requests so bit 0 is rr_ptr; lowest set bit is the winner's offset.
   always_comb begin
      req2 = {core_req, core_req} >> rr_ptr_q;
      rot  = req2[NUM_CORES-1:0];
      off  = '0;
      for (int k = NUM_CORES-1; k >= 0; k--) if (rot[k]) off = 3'(k);
      sum  = {1'b0, rr_ptr_q} + {1'b0, off};
      win  = (sum >= 4'(NUM_CORES)) ? 3'(sum - 4'(NUM_CORES)) : sum[2:0];
   end

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         if (3'(k) == win) begin
            sel_we    = core_we[k];
            sel_addr  = core_addr[k*ADDR_W +: ADDR_W];
            sel_wdata = core_wdata[k*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      owner_d       = owner_q;
      wd_d          = wd_q;
      gnt_d         = '0;
      valid_d       = '0;
      rdata_d       = rdata_q;
      mem_req_d     = mem_req_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      err_d         = err_q;
      err_core_d    = err_core_q;
      grant_count_d = grant_count_q;
      case (state_q)
         IDLE: if (|core_req) begin
            gnt_d         = NUM_CORES'(1) << win;
            owner_d       = win;
            rr_ptr_d      = (win == 3'(NUM_CORES-1)) ? 3'd0 : win + 3'd1;
            grant_count_d = grant_count_q + 32'd1;
            mem_req_d     = 1'b1;
            mem_we_d      = sel_we;
            mem_addr_d    = sel_addr;
            mem_wdata_d   = sel_wdata;
            state_d       = ISSUE;
         end
         ISSUE: if (mem_ready) begin
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
            wd_d        = '0;
            state_d     = mem_we_q ? IDLE : RD_WAIT;
         end
         RD_WAIT: begin
            if (mem_rvalid) begin
               valid_d = NUM_CORES'(1) << owner_q;
               rdata_d = mem_rdata;
               state_d = IDLE;
            end else if (wd_q == WD_W'(TIMEOUT-1)) begin
               // Release the core with zero data so it never hangs on a lost response.
               valid_d    = NUM_CORES'(1) << owner_q;
               rdata_d    = '0;
               err_d      = 1'b1;
               err_core_d = err_q ? err_core_q : owner_q;
               state_d    = IDLE;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         rr_ptr_q      <= '0;
         owner_q       <= '0;
         wd_q          <= '0;
         gnt_q         <= '0;
         valid_q       <= '0;
         rdata_q       <= '0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         err_q         <= 1'b0;
         err_core_q    <= '0;
         grant_count_q <= '0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         owner_q       <= owner_d;
         wd_q          <= wd_d;
         gnt_q         <= gnt_d;
         valid_q       <= valid_d;
         rdata_q       <= rdata_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         err_q         <= err_d;
         err_core_q    <= err_core_d;
         grant_count_q <= grant_count_d;
      end
   end

   assign core_gnt    = gnt_q;
   assign core_valid  = valid_q;
   assign core_rdata  = rdata_q;
   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign err_timeout = err_q;
   assign err_core    = err_core_q;
   assign grant_count = grant_count_q;
endmodule

// File: doc/ntt_mem_arbiter.md
# ntt_mem_arbiter

Round-robin arbiter that shares one external memory port between `NUM_CORES` NTT engine cores. Each core has its own req/we/addr/wdata/gnt/valid channel. The arbiter grants one transaction at a time, drives the shared memory port, and routes read data back to the core that issued the read. It sits between the engine array and the DMA/memory interface, and it adds a read-response watchdog with error reporting.

## Interface
- `NUM_CORES`, 4: number of requesting cores, 2..8.
- `ADDR_W`, 48: byte address width.
- `DATA_W`, 64: data word width.
- `TIMEOUT`, 1024: maximum cycles spent waiting for a read response; must be ≥ 2.

- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `core_req` in NUM_CORES: per-core request level, held until grant is seen.
- `core_we` in NUM_CORES: 1 = write, 0 = read.
- `core_addr` in NUM_CORES*ADDR_W: core i occupies bits [i*ADDR_W +: ADDR_W].
- `core_wdata` in NUM_CORES*DATA_W: core i occupies bits [i*DATA_W +: DATA_W].
- `core_gnt` out NUM_CORES: one-cycle, one-hot grant pulse.
- `core_valid` out NUM_CORES: one-cycle, one-hot read-data-valid pulse.
- `core_rdata` out DATA_W: read data, shared by all cores, qualified by `core_valid`.
- `mem_req` out 1: memory request.
- `mem_we` out 1: memory write enable.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_ready` in 1: memory accepts the request in this cycle when `mem_req && mem_ready`.
- `mem_rvalid` in 1: read response valid.
- `mem_rdata` in DATA_W: read response data.
- `err_timeout` out 1: sticky flag; set when a read times out.
- `err_core` out 3: index of the core whose read first timed out.
- `grant_count` out 32: total number of grants issued; wraps.

## Operation
- States:
  - IDLE: evaluate requests.
  - ISSUE: drive the memory port.
  - RD_WAIT: wait for read data.
- IDLE:
  - If any `core_req` is high, pick winner w. The search starts at `rr_ptr` and increases modulo NUM_CORES; the first core with req set wins.
  - Latch `core_we[w]`, `core_addr[w]`, `core_wdata[w]` and the owner id w.
  - Pulse `core_gnt[w]` and go to ISSUE.
  - Set `rr_ptr` to (w+1) mod NUM_CORES and increment `grant_count`.
  - No request: stay in IDLE with all outputs idle.
- ISSUE:
  - `mem_req` = 1, with the latched we/addr/wdata held stable until `mem_ready`.
  - On `mem_ready`: a write goes to IDLE; a read goes to RD_WAIT and clears the watchdog counter.
- RD_WAIT:
  - On `mem_rvalid`, the next cycle has `core_valid[owner]` = 1 and `core_rdata` = `mem_rdata`; state returns to IDLE.
  - Otherwise the watchdog increments. When it reaches TIMEOUT-1 without `mem_rvalid`:
    - Pulse `core_valid[owner]` with `core_rdata` = 0 so the core does not hang.
    - Set `err_timeout`; `err_core` = owner, captured only on the first timeout.
    - Return to IDLE.
- Requests in ISSUE/RD_WAIT are not evaluated; cores keep req asserted until granted.
- The granted core drops req no later than the cycle after `core_gnt`. ISSUE lasts at least one cycle, so IDLE never re-sees the same stale request.
- A `mem_rvalid` in IDLE or ISSUE is stray and is ignored. A late response arriving after a timeout is also ignored.
- Simultaneous requests from all cores are served in rotation i, i+1, …; no core waits more than NUM_CORES-1 grants.
- `err_timeout` clears only on reset.

## Timing
- Reset values:
  - state = IDLE, `rr_ptr` = 0.
  - `core_gnt` = 0, `core_valid` = 0, `core_rdata` = 0.
  - `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `err_timeout` = 0, `err_core` = 0, `grant_count` = 0.
- Reset asserted mid-transaction aborts it immediately. No `core_valid` is emitted, and any later `mem_rvalid` is ignored.
- Outputs are registered. Read request sampled at cycle t:
  - `core_gnt` and `mem_req` are high at t+1.
  - If `mem_ready` at t+1 and `mem_rvalid` at t+1+L, then `core_valid` is high at t+2+L.
- Write: gnt at t+1, accepted at t+1 with `mem_ready`, IDLE at t+2. Back-to-back writes give one grant every 2 cycles at best.
- `core_gnt` and `core_valid` are never high for more than one core in any cycle.

## Test plan
- Single read: core 2 reads addr 0x1000, memory returns 0xDEADBEEF with L=3 → `core_gnt[2]` at t+1, `core_valid[2]` at t+5 with `core_rdata` 0xDEADBEEF, `grant_count` = 1.
- All 4 cores hold writes, `rr_ptr` = 0 → grants in order 0,1,2,3,0 spaced 2 cycles apart; `mem_addr` matches each core's address.
- Backpressure: `mem_ready` low for 5 cycles → `mem_req`/`mem_addr`/`mem_wdata` stable for 6 cycles, then IDLE; no second grant in that window.
- Timeout: TIMEOUT=16, core 1 reads, `mem_rvalid` never asserted → `core_valid[1]` with data 0 after 16 RD_WAIT cycles, `err_timeout` = 1, `err_core` = 1; a later stray `mem_rvalid` produces no `core_valid`.
- Reset mid-read: `rst_n` pulled low in RD_WAIT → all outputs at reset values asynchronously; after release, `mem_rvalid` is ignored and the next request is granted normally with `rr_ptr` = 0.
